// File: rtl/udp_frame_bank_ctrl_if.sv
// Handshake bundle between the UDP unpacker, the frame bank controller and
// the frame read/write engine. The controller uses the slave modport.
interface udp_frame_bank_ctrl_if;
   logic up_write_req;
   logic up_write_req_ack;
   logic up_write_en;
   logic fw_write_req;
   logic fw_write_req_ack;
   logic read_frame_req;

   modport master (
      output up_write_req,
      output up_write_en,
      output fw_write_req_ack,
      output read_frame_req,
      input  up_write_req_ack,
      input  fw_write_req
   );

   modport slave (
      input  up_write_req,
      input  up_write_en,
      input  fw_write_req_ack,
      input  read_frame_req,
      output up_write_req_ack,
      output fw_write_req
   );
endinterface

// File: rtl/udp_frame_bank_ctrl.sv
// Triple-buffer bank controller: sequences UDP frame writes into SDRAM banks,
// commits complete frames, drops stalled or restarted ones, and swaps the display bank.
module udp_frame_bank_ctrl #(
   parameter int PIXEL_COUNT = 307200,
   parameter int TIMEOUT_CYC = 12500000,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   udp_frame_bank_ctrl_if.slave bus,
   output logic [1:0]           write_bank,
   output logic [1:0]           read_bank,
   output logic                 frame_done,
   output logic                 frame_drop,
   output logic                 busy,
   output logic [CNT_W-1:0]     done_cnt,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int PIX_W = 19;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(PIXEL_COUNT);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_COUNT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t           state;
   logic             req_q;
   logic             fw_req_q;
   logic             newest_valid;
   logic [1:0]       newest;
   logic [PIX_W-1:0] pix_cnt;
   logic [TMO_W-1:0] tmo;

   logic       req_edge;
   logic       pix_full_next;
   logic       timeout;
   logic       commit;
   logic       restart;
   logic [1:0] sel_bank;

   assign req_edge = bus.up_write_req & ~req_q;
   assign busy     = (state != S_IDLE);

   assign bus.fw_write_req     = fw_req_q;
   assign bus.up_write_req_ack = bus.fw_write_req_ack & (state == S_REQ);

   // Frame is full once this cycle's write (if any) has been counted.
   assign pix_full_next = bus.up_write_en ? (pix_cnt >= PIX_LAST) : (pix_cnt >= PIX_FULL);
   assign timeout       = busy & ~bus.up_write_en & (tmo == TMO_LAST);

   // A frame filled before the engine acked is committed on the ack cycle.
   assign commit = ((state == S_REQ) & bus.fw_write_req_ack & ~timeout & pix_full_next) |
                   ((state == S_ACTIVE) & bus.up_write_en & (pix_cnt >= PIX_LAST));
   assign restart = (state == S_ACTIVE) & req_edge & ~commit;

   // NOTE: every output of an always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      sel_bank = 2'd0;
      if (newest_valid)
         sel_bank = 2'd3 - read_bank - newest;  // the one bank neither displayed nor newest
      else
         sel_bank = (read_bank == 2'd2) ? 2'd0 : read_bank + 2'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         req_q        <= 1'b0;
         fw_req_q     <= 1'b0;
         write_bank   <= 2'd1;
         read_bank    <= 2'd0;
         newest_valid <= 1'b0;
         newest       <= 2'd0;
         pix_cnt      <= '0;
         tmo          <= '0;
         frame_done   <= 1'b0;
         frame_drop   <= 1'b0;
         done_cnt     <= '0;
         drop_cnt     <= '0;
      end else begin
         req_q      <= bus.up_write_req;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_edge) begin
                  write_bank <= sel_bank;
                  fw_req_q   <= 1'b1;
                  pix_cnt    <= '0;
                  tmo        <= '0;
                  state      <= S_REQ;
               end
            end
            default: begin
               if (bus.up_write_en) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  tmo     <= '0;
               end else begin
                  tmo <= tmo + 1'b1;
               end

               if (commit) begin
                  newest       <= write_bank;
                  newest_valid <= 1'b1;
                  frame_done   <= 1'b1;
                  done_cnt     <= done_cnt + 1'b1;
                  fw_req_q     <= 1'b0;
                  state        <= S_IDLE;
               end else if (restart) begin
                  // Upstream restarted the frame: rewrite the same bank from scratch.
                  frame_drop <= 1'b1;
                  drop_cnt   <= drop_cnt + 1'b1;
                  fw_req_q   <= 1'b1;
                  pix_cnt    <= '0;
                  tmo        <= '0;
                  state      <= S_REQ;
               end else if (timeout) begin
                  frame_drop <= 1'b1;
                  drop_cnt   <= drop_cnt + 1'b1;
                  fw_req_q   <= 1'b0;
                  state      <= S_IDLE;
               end else if ((state == S_REQ) && bus.fw_write_req_ack) begin
                  fw_req_q <= 1'b0;
                  state    <= S_ACTIVE;
               end
            end
         endcase

         // Display swap; a commit in the same cycle hands its bank straight over.
         if (bus.read_frame_req) begin
            if (commit) begin
               read_bank    <= write_bank;
               newest_valid <= 1'b0;
            end else if (newest_valid && (newest != read_bank)) begin
               read_bank    <= newest;
               newest_valid <= 1'b0;
            end
         end
      end
   end

endmodule
